// File: rtl/jtag_gpio_bank.sv
// jtag_gpio_bank: JTAG-controlled GPIO bank with open-drain pads, input synchroniser and sticky edge flags.
// Optional feature: define JTAG_GPIO_EDGE_EN to build the edge flags, history stage and edge_pending.
module jtag_gpio_bank #(
   parameter int                  NR_GPIOS      = 8,
   parameter int                  SYNC_STAGES   = 2,
   parameter logic [NR_GPIOS-1:0] OUT_RESET_VAL = '0
) (
   input  logic                tck,
   input  logic                reset_,
   input  logic                tdi,
   output logic                gpios_tdo,
   input  logic                capture_dr,
   input  logic                shift_dr,
   input  logic                update_dr,
   input  logic                scan_n_ir,
   input  logic                extest_ir,
   input  logic [NR_GPIOS-1:0] gpio_inputs,
   output logic [NR_GPIOS-1:0] gpio_outputs,
   output logic [NR_GPIOS-1:0] gpio_outputs_ena,
   output logic                edge_pending
);
   localparam logic [1:0] SEL_DATA = 2'd0;
   localparam logic [1:0] SEL_OE   = 2'd1;
   localparam logic [1:0] SEL_OD   = 2'd2;

   logic [1:0]          sel_q, sel_d, sel_sr_q, sel_sr_d;
   logic [NR_GPIOS-1:0] dat_sr_q, dat_sr_d, out_q, out_d, oe_q, oe_d, od_q, od_d;
   logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
   logic [NR_GPIOS-1:0] sync_d [SYNC_STAGES];
   logic [NR_GPIOS-1:0] sync_last, edge_val, cap_val, dat_shift;
   logic                scan_en, ext_en, ext_upd;

   // SCAN_N outranks EXTEST; update only counts when no other strobe is present
   always_comb begin
      scan_en   = scan_n_ir;
      ext_en    = extest_ir & ~scan_n_ir;
      ext_upd   = ext_en & update_dr & ~capture_dr & ~shift_dr;
      sync_last = sync_q[SYNC_STAGES-1];
   end

   // input synchroniser chain, stage 0 samples the pads
   always_comb begin
      sync_d[0] = gpio_inputs;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
   end

`ifdef JTAG_GPIO_EDGE_EN
   logic [NR_GPIOS-1:0] hist_q, edge_q, edge_d;

   // sticky edge flags: write-1-to-clear, a new edge in the same cycle wins over the clear
   always_comb edge_d = (edge_q & ~((ext_upd && sel_q == 2'd3) ? dat_sr_q : '0)) | (sync_last ^ hist_q);

   // edge flags and history stage
   always_ff @(posedge tck or negedge reset_)
      if (!reset_) begin
         hist_q <= '0;
         edge_q <= '0;
      end else begin
         hist_q <= sync_last;
         edge_q <= edge_d;
      end

   assign edge_val = edge_q;
`else
   assign edge_val = '0;
`endif

   assign edge_pending = |edge_val;

   // next-state for the select chain, data chain and the three control registers
   always_comb begin
      sel_sr_d  = (scan_en && capture_dr) ? sel_q : (scan_en && shift_dr) ? {tdi, sel_sr_q[1]} : sel_sr_q;
      sel_d     = (scan_en && update_dr && !capture_dr && !shift_dr) ? sel_sr_q : sel_q;
      cap_val   = sel_q == SEL_DATA ? sync_last : sel_q == SEL_OE ? oe_q : sel_q == SEL_OD ? od_q : edge_val;
      dat_shift = dat_sr_q >> 1;
      dat_shift[NR_GPIOS-1] = tdi;
      dat_sr_d  = (ext_en && capture_dr) ? cap_val : (ext_en && shift_dr) ? dat_shift : dat_sr_q;
      out_d     = (ext_upd && sel_q == SEL_DATA) ? dat_sr_q : out_q;
      oe_d      = (ext_upd && sel_q == SEL_OE) ? dat_sr_q : oe_q;
      od_d      = (ext_upd && sel_q == SEL_OD) ? dat_sr_q : od_q;
   end

   // all bank state; reset aborts any scan in progress
   always_ff @(posedge tck or negedge reset_)
      if (!reset_) begin
         sel_q    <= '0;
         sel_sr_q <= '0;
         dat_sr_q <= '0;
         out_q    <= OUT_RESET_VAL;
         oe_q     <= '0;
         od_q     <= '0;
         sync_q   <= '{default: '0};
      end else begin
         sel_q    <= sel_d;
         sel_sr_q <= sel_sr_d;
         dat_sr_q <= dat_sr_d;
         out_q    <= out_d;
         oe_q     <= oe_d;
         od_q     <= od_d;
         sync_q   <= sync_d;
      end

   // pad drive: open-drain pins only ever pull low, by enabling a forced-0 output
   always_comb begin
      gpio_outputs     = out_q & ~od_q;
      gpio_outputs_ena = oe_q & ~(od_q & out_q);
      gpios_tdo        = scan_n_ir ? sel_sr_q[0] : dat_sr_q[0];
   end
endmodule

// File: tb/tb_jtag_gpio_bank.sv
// tb_jtag_gpio_bank: directed and randomized check of jtag_gpio_bank against a behavioural model.
module tb_jtag_gpio_bank;
   localparam int N = 8;
   localparam int S = 2;
`ifdef JTAG_GPIO_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic         tck = 0, reset_ = 0, tdi = 0;
   logic         capture_dr = 0, shift_dr = 0, update_dr = 0, scan_n_ir = 0, extest_ir = 0;
   logic [N-1:0] gpio_inputs = '0;
   logic         gpios_tdo, edge_pending;
   logic [N-1:0] gpio_outputs, gpio_outputs_ena;
   int           tests = 0, fails = 0;

   logic [1:0]   m_sel, m_ssr;
   logic [N-1:0] m_dat, m_out, m_oe, m_od, m_edge;
   logic [N-1:0] ih[$];

   jtag_gpio_bank #(.NR_GPIOS(N), .SYNC_STAGES(S), .OUT_RESET_VAL(8'h00)) dut (
      .tck(tck), .reset_(reset_), .tdi(tdi), .gpios_tdo(gpios_tdo),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .scan_n_ir(scan_n_ir), .extest_ir(extest_ir), .gpio_inputs(gpio_inputs),
      .gpio_outputs(gpio_outputs), .gpio_outputs_ena(gpio_outputs_ena), .edge_pending(edge_pending)
   );

   always #5 tck = ~tck;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sel = 0; m_ssr = 0; m_dat = 0; m_out = 0; m_oe = 0; m_od = 0; m_edge = 0;
      ih.delete();
      repeat (S + 1) ih.push_back('0);
   endtask

   // ih[k] is the pad value sampled k+1 edges ago; the synchronised view lags by S edges
   task automatic model_step(input logic c, input logic s, input logic u, input logic t);
      logic [N-1:0] syncd, prev;
      if (!reset_) return;
      syncd = ih[S-1];
      prev  = ih[S];
      if (scan_n_ir) begin
         if (c) m_ssr = m_sel;
         else if (s) m_ssr = {t, m_ssr[1]};
         else if (u) m_sel = m_ssr;
      end else if (extest_ir) begin
         if (c) m_dat = m_sel == 0 ? syncd : m_sel == 1 ? m_oe : m_sel == 2 ? m_od : m_edge;
         else if (s) m_dat = {t, m_dat[N-1:1]};
         else if (u) begin
            if (m_sel == 0) m_out = m_dat;
            if (m_sel == 1) m_oe = m_dat;
            if (m_sel == 2) m_od = m_dat;
            if (EDGE && m_sel == 3) m_edge = m_edge & ~m_dat;
         end
      end
      if (EDGE) m_edge = m_edge | (syncd ^ prev);
      ih.push_front(gpio_inputs);
      void'(ih.pop_back());
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] eo, ee;
      for (int i = 0; i < N; i++) begin
         eo[i] = m_od[i] ? 1'b0 : m_out[i];
         ee[i] = m_od[i] ? (m_oe[i] & ~m_out[i]) : m_oe[i];
      end
      check({tag, "_out"}, gpio_outputs, eo);
      check({tag, "_ena"}, gpio_outputs_ena, ee);
      check({tag, "_tdo"}, gpios_tdo, scan_n_ir ? m_ssr[0] : m_dat[0]);
      check({tag, "_pend"}, edge_pending, |m_edge);
   endtask

   task automatic tick(input logic c, input logic s, input logic u, input logic t);
      capture_dr = c; shift_dr = s; update_dr = u; tdi = t;
      @(posedge tck);
      model_step(c, s, u, t);
      @(negedge tck);
      capture_dr = 0; shift_dr = 0; update_dr = 0;
   endtask

   task automatic scan_sel(input logic [1:0] v, output logic [1:0] rd);
      logic [1:0] exp;
      exp = m_sel;
      scan_n_ir = 1; extest_ir = 0;
      tick(1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         rd[i] = gpios_tdo;
         tick(0, 1, 0, v[i]);
      end
      tick(0, 0, 1, 0);
      scan_n_ir = 0;
      check("scan_rd", rd, exp);
   endtask

   task automatic dr(input logic [N-1:0] v, input int tog_at, input logic [N-1:0] tog, output logic [N-1:0] rd);
      logic [N-1:0] exp;
      extest_ir = 1;
      tick(1, 0, 0, 0);
      exp = m_dat;
      for (int i = 0; i < N; i++) begin
         if (i == tog_at) gpio_inputs = gpio_inputs ^ tog;
         rd[i] = gpios_tdo;
         tick(0, 1, 0, v[i]);
      end
      tick(0, 0, 1, 0);
      extest_ir = 0;
      check("dr_rd", rd, exp);
      check_all("dr");
   endtask

   initial begin
      logic [1:0]   r2;
      logic [N-1:0] r8;
      int           k;
      model_reset();
      repeat (2) @(negedge tck);
      check_all("rst");
      check("rst_ena", gpio_outputs_ena, 8'h00);
      check("rst_out", gpio_outputs, 8'h00);
      reset_ = 1;
      scan_sel(2'd0, r2);
      check("scan_after_rst", r2, 2'd0);
      check("ena_after_rst", gpio_outputs_ena, 8'h00);

      scan_sel(2'd1, r2);
      dr(8'hA5, -1, '0, r8);
      scan_sel(2'd0, r2);
      check("sel_readback", r2, 2'd1);
      dr(8'h3C, -1, '0, r8);
      check("pp_out", gpio_outputs, 8'h3C);
      check("pp_ena", gpio_outputs_ena, 8'hA5);

      scan_sel(2'd1, r2); dr(8'hFF, -1, '0, r8);
      scan_sel(2'd2, r2); dr(8'h0F, -1, '0, r8);
      scan_sel(2'd0, r2); dr(8'h55, -1, '0, r8);
      check("od_out", gpio_outputs, 8'h50);
      check("od_ena", gpio_outputs_ena, 8'hFA);

      gpio_inputs = 8'h81;
      repeat (3) tick(0, 0, 0, 0);
      dr(8'h55, -1, '0, r8);
      check("data_capture", r8, 8'h81);
      check("data_out_kept", gpio_outputs, 8'h50);

      scan_sel(2'd3, r2);
      dr(8'hFF, -1, '0, r8);
      dr(8'h00, -1, '0, r8);
      check("edge_cleared", r8, 8'h00);
      gpio_inputs = gpio_inputs ^ 8'h08;
      repeat (3) tick(0, 0, 0, 0);
      check("edge_pend_set", edge_pending, EDGE);
      dr(8'h08, 6, 8'h08, r8);
      check("edge_cap", r8, EDGE ? 8'h08 : 8'h00);
      check("edge_set_wins", edge_pending, EDGE);
      dr(8'h08, -1, '0, r8);
      check("edge_cap2", r8, EDGE ? 8'h08 : 8'h00);
      check("edge_pend_clr", edge_pending, 1'b0);

      repeat (300) begin
         k = $urandom_range(0, 3);
         scan_n_ir = k[0];
         extest_ir = k[1];
         if ($urandom_range(0, 7) == 0) gpio_inputs = N'($urandom);
         k = $urandom_range(0, 3);
         tick(k == 1, k == 2, k == 3, 1'($urandom));
         check_all("rnd");
      end
      scan_n_ir = 0; extest_ir = 0;

      scan_sel(2'd2, r2); dr(8'h00, -1, '0, r8);
      scan_sel(2'd0, r2); dr(8'h00, -1, '0, r8);
      scan_sel(2'd1, r2); dr(8'hFF, -1, '0, r8);
      check("pre_rst_ena", gpio_outputs_ena, 8'hFF);
      extest_ir = 1;
      tick(1, 0, 0, 0);
      repeat (4) tick(0, 1, 0, 1'b0);
      reset_ = 0;
      #1;
      model_reset();
      check("midrst_ena", gpio_outputs_ena, 8'h00);
      check("midrst_out", gpio_outputs, 8'h00);
      check_all("midrst");
      tick(0, 0, 1, 0);
      reset_ = 1;
      extest_ir = 0;
      check("post_rst_ena", gpio_outputs_ena, 8'h00);
      scan_sel(2'd0, r2);
      check("post_rst_sel", r2, 2'd0);
      check_all("end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
